// File: rtl/lsu_pipe_if.sv
// rtl/lsu_pipe_if.sv - bypass packet type and data-memory request/acknowledge bus
package lsu_pipe_pkg;
  typedef struct packed {
    logic        gpr_we;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        fpr_we;
    logic [4:0]  fpr_waddr;
    logic [31:0] fpr_wdata;
    logic        need_load;
  } bypass_t;
endpackage

interface lsu_pipe_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/lsu_pipe.sv
// rtl/lsu_pipe.sv - EX->MEM->WB slice with data-memory handshake and bypass packets
module lsu_pipe
  import lsu_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        flush,
  input  logic        ex_gpr_we,
  input  logic        ex_fpr_we,
  input  logic [4:0]  ex_gpr_waddr,
  input  logic [4:0]  ex_fpr_waddr,
  input  logic [31:0] ex_result,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [1:0]  ex_ls_size,
  input  logic        ex_ls_unsigned,
  input  logic [31:0] ex_store_data,
  output bypass_t     exu_bypass,
  output bypass_t     lsu_bypass,
  lsu_pipe_if.master  mem,
  output logic        wb_gpr_we,
  output logic        wb_fpr_we,
  output logic [4:0]  wb_gpr_waddr,
  output logic [4:0]  wb_fpr_waddr,
  output logic [31:0] wb_wdata
);

  typedef enum logic [1:0] {S_EMPTY, S_ALU, S_REQ, S_DONE} state_t;

  state_t      state;
  logic        s_gpr_we, s_fpr_we, s_load, s_store, s_uns;
  logic [4:0]  s_gpr_waddr, s_fpr_waddr;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_sdata, s_wdata;

  logic        accept, ex_live, slot_live;
  logic [3:0]  be;
  logic [31:0] lane_wdata, load_data;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign ex_ready  = (state != S_REQ);
  assign ex_live   = ex_valid & ~flush;
  assign accept    = ex_live & ex_ready;
  assign slot_live = (state != S_EMPTY) & ~s_store;

  always_comb begin
    exu_bypass.gpr_we    = ex_live & ex_gpr_we;
    exu_bypass.gpr_waddr = ex_gpr_waddr;
    exu_bypass.gpr_wdata = ex_result;
    exu_bypass.fpr_we    = ex_live & ex_fpr_we;
    exu_bypass.fpr_waddr = ex_fpr_waddr;
    exu_bypass.fpr_wdata = ex_result;
    exu_bypass.need_load = ex_live & ex_is_load;

    lsu_bypass.gpr_we    = slot_live & s_gpr_we;
    lsu_bypass.gpr_waddr = s_gpr_waddr;
    lsu_bypass.gpr_wdata = s_wdata;
    lsu_bypass.fpr_we    = slot_live & s_fpr_we;
    lsu_bypass.fpr_waddr = s_fpr_waddr;
    lsu_bypass.fpr_wdata = s_wdata;
    lsu_bypass.need_load = (state == S_REQ) & s_load;
  end

  // Byte-lane steering; address bits below the access size are ignored.
  always_comb begin
    be         = 4'b1111;
    lane_wdata = s_sdata;
    case (s_size)
      2'd0: begin
        be         = 4'b0001 << s_addr[1:0];
        lane_wdata = {4{s_sdata[7:0]}};
      end
      2'd1: begin
        be         = 4'b0011 << {s_addr[1], 1'b0};
        lane_wdata = {2{s_sdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rbyte     = mem.mem_rdata[{s_addr[1:0], 3'b000} +: 8];
    rhalf     = mem.mem_rdata[{s_addr[1], 4'b0000} +: 16];
    load_data = mem.mem_rdata;
    case (s_size)
      2'd0:    load_data = {{24{rbyte[7] & ~s_uns}}, rbyte};
      2'd1:    load_data = {{16{rhalf[15] & ~s_uns}}, rhalf};
      default: ;
    endcase
  end

  assign mem.mem_req   = (state == S_REQ);
  assign mem.mem_we    = s_store;
  assign mem.mem_addr  = s_addr;
  assign mem.mem_be    = be;
  assign mem.mem_wdata = lane_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_EMPTY;
      s_gpr_we     <= 1'b0;
      s_fpr_we     <= 1'b0;
      s_load       <= 1'b0;
      s_store      <= 1'b0;
      s_uns        <= 1'b0;
      s_gpr_waddr  <= '0;
      s_fpr_waddr  <= '0;
      s_size       <= '0;
      s_addr       <= '0;
      s_sdata      <= '0;
      s_wdata      <= '0;
      wb_gpr_we    <= 1'b0;
      wb_fpr_we    <= 1'b0;
      wb_gpr_waddr <= '0;
      wb_fpr_waddr <= '0;
      wb_wdata     <= '0;
    end else begin
      wb_gpr_we <= 1'b0;
      wb_fpr_we <= 1'b0;
      if (state == S_ALU || state == S_DONE) begin
        wb_gpr_we    <= s_gpr_we;
        wb_fpr_we    <= s_fpr_we;
        wb_gpr_waddr <= s_gpr_waddr;
        wb_fpr_waddr <= s_fpr_waddr;
        wb_wdata     <= s_wdata;
      end

      case (state)
        S_REQ: begin
          if (mem.mem_ack) begin
            if (s_load) begin
              s_wdata <= load_data;
              state   <= S_DONE;
            end else begin
              state   <= S_EMPTY;
            end
          end
        end
        default: begin
          if (accept) begin
            s_gpr_we    <= ex_gpr_we;
            s_fpr_we    <= ex_fpr_we;
            s_gpr_waddr <= ex_gpr_waddr;
            s_fpr_waddr <= ex_fpr_waddr;
            s_load      <= ex_is_load;
            s_store     <= ex_is_store;
            s_size      <= ex_ls_size;
            s_uns       <= ex_ls_unsigned;
            s_addr      <= ex_result;
            s_sdata     <= ex_store_data;
            s_wdata     <= ex_result;
            state       <= (ex_is_load | ex_is_store) ? S_REQ : S_ALU;
          end else begin
            state <= S_EMPTY;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_pipe.sv
// tb/tb_lsu_pipe.sv - scoreboard bench for lsu_pipe with randomized loads, stores and ALU ops
module tb_lsu_pipe;
  import lsu_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ex_valid, ex_ready, flush;
  logic        ex_gpr_we, ex_fpr_we;
  logic [4:0]  ex_gpr_waddr, ex_fpr_waddr;
  logic [31:0] ex_result, ex_store_data;
  logic        ex_is_load, ex_is_store, ex_ls_unsigned;
  logic [1:0]  ex_ls_size;
  bypass_t     exu_bypass, lsu_bypass;
  logic        wb_gpr_we, wb_fpr_we;
  logic [4:0]  wb_gpr_waddr, wb_fpr_waddr;
  logic [31:0] wb_wdata;

  lsu_pipe_if mem ();

  lsu_pipe dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .flush(flush),
    .ex_gpr_we(ex_gpr_we), .ex_fpr_we(ex_fpr_we),
    .ex_gpr_waddr(ex_gpr_waddr), .ex_fpr_waddr(ex_fpr_waddr),
    .ex_result(ex_result), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_ls_size(ex_ls_size), .ex_ls_unsigned(ex_ls_unsigned),
    .ex_store_data(ex_store_data),
    .exu_bypass(exu_bypass), .lsu_bypass(lsu_bypass),
    .mem(mem),
    .wb_gpr_we(wb_gpr_we), .wb_fpr_we(wb_fpr_we),
    .wb_gpr_waddr(wb_gpr_waddr), .wb_fpr_waddr(wb_fpr_waddr),
    .wb_wdata(wb_wdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          lat;
  } req_t;

  typedef struct {
    logic        gwe;
    logic        fwe;
    logic [4:0]  ga;
    logic [4:0]  fa;
    logic [31:0] data;
  } wb_t;

  req_t        req_q[$];
  wb_t         wb_q[$];
  logic [31:0] mem_model [256];
  int          next_lat = -1;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return 4'(1 << (a % 4));
    if (sz == 2'd1) return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    logic [31:0] w, v;
    w = mem_model[a[9:2]];
    if (sz == 2'd0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v >= 128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32768) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Memory responder: checks each request against the expected queue and its stability.
  initial begin
    req_t cur;
    int   wcnt, lat;
    bit   in_req;
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = '0;
    in_req = 0; wcnt = 0; lat = 0;
    cur = '{we: 1'b0, addr: '0, be: '0, wdata: '0, lat: 0};
    forever begin
      @(negedge clk);
      mem.mem_ack   = 1'b0;
      mem.mem_rdata = $urandom;
      if (mem.mem_req && !rst) begin
        if (!in_req) begin
          in_req = 1; wcnt = 0;
          if (req_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_req actual=%h required=none", mem.mem_addr);
            cur = '{we: mem.mem_we, addr: mem.mem_addr, be: mem.mem_be, wdata: mem.mem_wdata, lat: 0};
          end else begin
            cur = req_q.pop_front();
          end
          lat = (cur.lat < 0) ? int'($urandom_range(0, 3)) : cur.lat;
        end
        chk("req_addr", mem.mem_addr, cur.addr);
        chk("req_we", 32'(mem.mem_we), 32'(cur.we));
        chk("req_be", 32'(mem.mem_be), 32'(cur.be));
        if (cur.we) chk("req_wdata", mem.mem_wdata, cur.wdata);
        if (wcnt >= lat) begin
          mem.mem_ack   = 1'b1;
          mem.mem_rdata = mem_model[mem.mem_addr[9:2]];
          in_req = 0;
        end else begin
          wcnt++;
        end
      end else begin
        in_req = 0;
      end
    end
  end

  // Writeback monitor.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && (wb_gpr_we || wb_fpr_we)) begin
        if (wb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_wb actual=%h required=none", wb_wdata);
        end else begin
          e = wb_q.pop_front();
          chk("wb_gpr_we", 32'(wb_gpr_we), 32'(e.gwe));
          chk("wb_fpr_we", 32'(wb_fpr_we), 32'(e.fwe));
          if (e.gwe) chk("wb_gpr_waddr", 32'(wb_gpr_waddr), 32'(e.ga));
          if (e.fwe) chk("wb_fpr_waddr", 32'(wb_fpr_waddr), 32'(e.fa));
          chk("wb_wdata", wb_wdata, e.data);
        end
      end
    end
  end

  // kind: 0 = ALU, 1 = load, 2 = store. Called at a negedge, returns at a negedge.
  task automatic issue(input int kind, input logic gwe, input logic fwe,
                       input logic [4:0] ga, input logic [4:0] fa, input logic [31:0] res,
                       input logic [1:0] sz, input logic uns, input logic [31:0] sd, input bit fl);
    int tries;
    ex_valid = 1'b1; flush = fl;
    ex_gpr_we = gwe; ex_fpr_we = fwe; ex_gpr_waddr = ga; ex_fpr_waddr = fa;
    ex_result = res; ex_ls_size = sz; ex_ls_unsigned = uns; ex_store_data = sd;
    ex_is_load = (kind == 1); ex_is_store = (kind == 2);
    #1;
    chk("exu_gpr_we", 32'(exu_bypass.gpr_we), 32'(gwe & ~fl));
    chk("exu_fpr_we", 32'(exu_bypass.fpr_we), 32'(fwe & ~fl));
    chk("exu_need_load", 32'(exu_bypass.need_load), 32'((kind == 1) && !fl));
    chk("exu_wdata", exu_bypass.gpr_wdata, res);
    if (fl) begin
      @(negedge clk);
      ex_valid = 1'b0; flush = 1'b0;
      return;
    end
    tries = 0;
    while (!ex_ready && tries < 100) begin
      @(negedge clk); #1; tries++;
    end
    if (!ex_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=ex_ready=0 required=1");
    end else begin
      if (kind != 0)
        req_q.push_back('{we: (kind == 2), addr: res, be: ref_be(res, sz),
                          wdata: ref_wdata(sd, sz), lat: next_lat});
      if (kind != 2 && (gwe || fwe))
        wb_q.push_back('{gwe: gwe, fwe: fwe, ga: ga, fa: fa,
                         data: (kind == 1) ? ref_load(res, sz, uns) : res});
    end
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
    next_lat = -1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, kind;
    logic gwe, fwe;
    rst = 1'b1;
    ex_valid = 0; flush = 0; ex_gpr_we = 0; ex_fpr_we = 0; ex_gpr_waddr = 0; ex_fpr_waddr = 0;
    ex_result = 0; ex_is_load = 0; ex_is_store = 0; ex_ls_size = 0; ex_ls_unsigned = 0;
    ex_store_data = 0;
    for (int i = 0; i < 256; i++) mem_model[i] = $urandom;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_mem_req", 32'(mem.mem_req), 32'd0);
    chk("rst_wb_gpr_we", 32'(wb_gpr_we), 32'd0);
    chk("rst_wb_wdata", wb_wdata, 32'd0);
    chk("rst_lsu_need_load", 32'(lsu_bypass.need_load), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ALU forwarding x5 = 0x1234
    issue(0, 1, 0, 5'd5, 5'd0, 32'h1234, 2'd2, 0, 32'h0, 0);
    #1;
    chk("alu_lsu_gpr_we", 32'(lsu_bypass.gpr_we), 32'd1);
    chk("alu_lsu_waddr", 32'(lsu_bypass.gpr_waddr), 32'd5);
    chk("alu_lsu_wdata", lsu_bypass.gpr_wdata, 32'h1234);
    @(negedge clk); #1;
    chk("alu_wb_we", 32'(wb_gpr_we), 32'd1);
    chk("alu_wb_waddr", 32'(wb_gpr_waddr), 32'd5);
    chk("alu_wb_wdata", wb_wdata, 32'h1234);
    @(negedge clk);

    // lb from 0x103 with three REQ cycles
    mem_model[8'h40] = 32'h80AA_BBCC;
    next_lat = 2;
    issue(1, 1, 0, 5'd7, 5'd0, 32'h103, 2'd0, 0, 32'h0, 0);
    #1;
    n = 0;
    while (lsu_bypass.need_load && n < 20) begin
      chk("lb_ex_ready", 32'(ex_ready), 32'd0);
      n++;
      @(negedge clk); #1;
    end
    chk("lb_need_load_cycles", n, 32'd3);
    chk("lb_lsu_wdata", lsu_bypass.gpr_wdata, 32'hFFFF_FF80);
    chk("lb_lsu_gpr_we", 32'(lsu_bypass.gpr_we), 32'd1);
    @(negedge clk);

    // sh to 0x202
    next_lat = 1;
    issue(2, 0, 0, 5'd0, 5'd0, 32'h202, 2'd1, 0, 32'h0000_BEEF, 0);
    #1;
    chk("sh_mem_req", 32'(mem.mem_req), 32'd1);
    chk("sh_mem_be", 32'(mem.mem_be), 32'b1100);
    chk("sh_mem_wdata", mem.mem_wdata, 32'hBEEF_BEEF);
    chk("sh_mem_we", 32'(mem.mem_we), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("sh_done_req", 32'(mem.mem_req), 32'd0);
    chk("sh_done_ready", 32'(ex_ready), 32'd1);
    chk("sh_no_wb", 32'(wb_gpr_we), 32'd0);
    @(negedge clk);

    // lhu from 0x2
    mem_model[0] = 32'h8001_0000;
    issue(1, 1, 0, 5'd9, 5'd0, 32'h2, 2'd1, 1, 32'h0, 0);
    #1;
    n = 0;
    while (lsu_bypass.need_load && n < 20) begin
      n++;
      @(negedge clk); #1;
    end
    chk("lhu_lsu_wdata", lsu_bypass.gpr_wdata, 32'h0000_8001);
    @(negedge clk);

    // flushed load
    issue(1, 1, 1, 5'd3, 5'd4, 32'h10, 2'd2, 0, 32'h0, 1);
    #1;
    chk("flush_mem_req", 32'(mem.mem_req), 32'd0);
    chk("flush_ex_ready", 32'(ex_ready), 32'd1);
    chk("flush_lsu_we", 32'(lsu_bypass.gpr_we), 32'd0);
    @(negedge clk);

    // reset in the middle of a load request
    next_lat = 50;
    issue(1, 1, 0, 5'd11, 5'd0, 32'h40, 2'd2, 0, 32'h0, 0);
    #1;
    chk("rl_mem_req", 32'(mem.mem_req), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rl_mem_req_async", 32'(mem.mem_req), 32'd0);
    chk("rl_need_load", 32'(lsu_bypass.need_load), 32'd0);
    wb_q.delete();
    req_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rl_ex_ready", 32'(ex_ready), 32'd1);
    @(negedge clk);
    issue(0, 1, 0, 5'd12, 5'd0, 32'hCAFE, 2'd2, 0, 32'h0, 0);
    repeat (3) @(negedge clk);

    // randomized mix
    repeat (300) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      kind = int'($urandom_range(0, 2));
      gwe  = (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      fwe  = (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      issue(kind, gwe, fwe, 5'($urandom), 5'($urandom), 32'($urandom_range(0, 1023)),
            2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom,
            ($urandom_range(0, 9) == 0));
    end

    repeat (30) @(negedge clk);
    chk("drain_wb_q", wb_q.size(), 32'd0);
    chk("drain_req_q", req_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
